instr_loader: RTL and testbench

INSTR_LOADER -- requirements
Module: instr_loader

---
 rtl/instr_loader.sv | 183 ++++++++++++++++++
 tb/tb_instr_loader.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/instr_loader.sv
// instr_loader: loads a byte stream into instruction memory, little-endian,
// and flags the program valid (done / cs_rom) once the whole image has been written.
//
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte. A mismatch returns the loader to IDLE with err=1.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   start        one-cycle load request (honoured in IDLE / DONE only)
//   word_count   instructions to load, 0 means 64
//   byte_in      stream data byte, qualified by byte_valid
//   byte_valid   byte_in valid
//   byte_ready   loader accepts a byte (LOAD / CHECK)
//   mem_we       byte write strobe, one cycle after acceptance
//   mem_addr     byte write address
//   mem_wdata    byte write data
//   cs_rom       CPU-side fetch enable, equal to done
//   busy         load in progress
//   done         load completed, program valid
//   err          checksum failure, sticky until the next accepted start
module instr_loader #(
  parameter int unsigned BYTE              = 8,
  parameter int unsigned INSTRUCTION_WIDTH = 32,
  parameter int unsigned ROM_DEPTH         = 256
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [5:0]                   word_count,
  input  logic [BYTE-1:0]              byte_in,
  input  logic                         byte_valid,
  output logic                         byte_ready,
  output logic                         mem_we,
  output logic [INSTRUCTION_WIDTH-1:0] mem_addr,
  output logic [BYTE-1:0]              mem_wdata,
  output logic                         cs_rom,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned WC_W  = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ROM_DEPTH - 1);

`ifdef LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, CHECK = 2'd2, DONE = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd3} state_t;
`endif

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [WC_W-1:0]   wc_q;
  logic [WC_W-1:0]   wc_m1;
  logic [CNT_W-1:0]  last_idx;
  logic              accept_start;
  logic              xfer;
  logic              load_xfer;
  logic              load_end;
  logic              active_d;

  // Last byte index 4*N-1; N=0 wraps wc_m1 to 63, giving 255 (64 instructions).
  assign wc_m1    = wc_q - WC_W'(1);
  assign last_idx = {wc_m1, 2'b11};

  assign accept_start = start && (state_q == IDLE || state_q == DONE);
  assign xfer         = byte_valid && byte_ready;
  assign load_xfer    = xfer && (state_q == LOAD);
  // Counter bound also stops the load so no write can wrap past the memory.
  assign load_end     = (cnt_q == last_idx) || (cnt_q == CNT_MAX);

`ifdef LOADER_CHECKSUM_EN
  logic [BYTE-1:0] xor_q;
  logic            err_set;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
`ifdef LOADER_CHECKSUM_EN
    err_set = 1'b0;
`endif
    case (state_q)
      IDLE, DONE: if (accept_start) state_d = LOAD;
      LOAD: begin
        if (load_xfer && load_end) begin
`ifdef LOADER_CHECKSUM_EN
          state_d = CHECK;
`else
          state_d = DONE;
`endif
        end
      end
`ifdef LOADER_CHECKSUM_EN
      CHECK: begin
        if (xfer) begin
          if (byte_in == xor_q) begin
            state_d = DONE;
          end else begin
            state_d = IDLE;
            err_set = 1'b1;
          end
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef LOADER_CHECKSUM_EN
  assign active_d = (state_d == LOAD) || (state_d == CHECK);
`else
  assign active_d = (state_d == LOAD);
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Status outputs registered from the next state so they track the state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      byte_ready <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      cs_rom     <= 1'b0;
    end else begin
      byte_ready <= active_d;
      busy       <= active_d;
      done       <= (state_d == DONE);
      cs_rom     <= (state_d == DONE);
    end
  end

  // Memory write port: one-cycle-delayed copy of each accepted LOAD byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      mem_we <= load_xfer;
      if (load_xfer) begin
        mem_addr  <= INSTRUCTION_WIDTH'(cnt_q);
        mem_wdata <= byte_in;
      end
    end
  end

  // Byte counter and latched word count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      wc_q  <= '0;
    end else if (accept_start) begin
      cnt_q <= '0;
      wc_q  <= word_count;
    end else if (load_xfer) begin
      cnt_q <= load_end ? '0 : cnt_q + CNT_W'(1);
    end
  end

`ifdef LOADER_CHECKSUM_EN
  // Running XOR of LOAD bytes and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= '0;
      err   <= 1'b0;
    end else begin
      if (accept_start)   xor_q <= '0;
      else if (load_xfer) xor_q <= xor_q ^ byte_in;
      if (accept_start)   err <= 1'b0;
      else if (err_set)   err <= 1'b1;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_loader.sv
module tb_instr_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [5:0]  word_count = 6'd0;
  logic [7:0]  byte_in = 8'd0;
  logic        byte_valid = 1'b0;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        cs_rom;
  logic        busy;
  logic        done;
  logic        err;

  int n_chk = 0;
  int n_pass = 0;

  // Write log, captured at the rising edge (sees the previous cycle's strobe).
  logic [31:0] log_a [0:1023];
  logic [7:0]  log_d [0:1023];
  int          wr_n = 0;

  instr_loader dut (
    .clk(clk), .rst_n(rst_n), .start(start), .word_count(word_count),
    .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cs_rom(cs_rom), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we && wr_n < 1024) begin
      log_a[wr_n] <= mem_addr;
      log_d[wr_n] <= mem_wdata;
      wr_n        <= wr_n + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Called just after a negedge; returns at the negedge following the transfer.
  task automatic send(input logic [7:0] b);
    int guard = 0;
    byte_in    = b;
    byte_valid = 1'b1;
    while (!byte_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    byte_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic do_start(input logic [5:0] n);
    word_count = n;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_we"},    32'(mem_we),     32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_ready"}, 32'(byte_ready), 32'd0);
    check({tag, "_done"},  32'(done),       32'd0);
    check({tag, "_cs"},    32'(cs_rom),     32'd0);
    check({tag, "_err"},   32'(err),        32'd0);
    check({tag, "_addr"},  mem_addr,        32'd0);
    check({tag, "_wdata"}, 32'(mem_wdata),  32'd0);
  endtask

  initial begin
    logic [7:0] prog [0:3];
    int base;
    int zeros;
    prog[0] = 8'h08; prog[1] = 8'h00; prog[2] = 8'h01; prog[3] = 8'h20;

    // Reset state
    #1;
    check_zero("reset");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_zero("idle");

    // Basic load: one instruction, back-to-back bytes
    do_start(6'd1);
    check("basic_busy", 32'(busy), 32'd1);
    check("basic_ready", 32'(byte_ready), 32'd1);
    check("basic_we0", 32'(mem_we), 32'd0);
    for (int i = 0; i < 4; i++) begin
      send(prog[i]);
      check($sformatf("basic_we%0d", i), 32'(mem_we), 32'd1);
      check($sformatf("basic_addr%0d", i), mem_addr, 32'(i));
      check($sformatf("basic_data%0d", i), 32'(mem_wdata), 32'(prog[i]));
    end
    check("basic_done", 32'(done), 32'd1);
    check("basic_cs", 32'(cs_rom), 32'd1);
    check("basic_busy_end", 32'(busy), 32'd0);
    check("basic_err", 32'(err), 32'd0);
    idle(1);
    check("basic_we_after", 32'(mem_we), 32'd0);
    check("basic_addr_hold", mem_addr, 32'd3);
    check("basic_data_hold", 32'(mem_wdata), 32'h20);

    // Reload from DONE with backpressure, two instructions
    do_start(6'd2);
    check("reload_done", 32'(done), 32'd0);
    check("reload_cs", 32'(cs_rom), 32'd0);
    check("reload_busy", 32'(busy), 32'd1);
    base = wr_n;
    for (int i = 0; i < 8; i++) begin
      if (i == 7) check("bp_done_early", 32'(done), 32'd0);
      send(8'h10 + 8'(i));
      idle(1);
      check($sformatf("bp_gap_we%0d", i), 32'(mem_we), 32'd0);
    end
    check("bp_done", 32'(done), 32'd1);
    idle(2);
    check("bp_count", 32'(wr_n - base), 32'd8);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("bp_addr%0d", i), log_a[base + i], 32'(i));
      check($sformatf("bp_data%0d", i), 32'(log_d[base + i]), 32'(8'h10 + 8'(i)));
    end

    // Count zero means 64 instructions / 256 bytes
    do_start(6'd0);
    base = wr_n;
    for (int i = 0; i < 256; i++) send(8'(i));
    check("cz_done", 32'(done), 32'd1);
    idle(2);
    check("cz_count", 32'(wr_n - base), 32'd256);
    check("cz_last_addr", log_a[base + 255], 32'd255);
    check("cz_last_data", 32'(log_d[base + 255]), 32'hFF);
    zeros = 0;
    for (int i = 0; i < 256; i++) if (log_a[base + i] == 32'd0) zeros++;
    check("cz_addr0_once", 32'(zeros), 32'd1);

    // Start while busy is ignored; reset mid-load suppresses the pending write
    do_start(6'd2);
    base = wr_n;
    for (int i = 0; i < 3; i++) send(8'hA0 + 8'(i));
    word_count = 6'd1;
    start = 1'b1;
    send(8'hA3);
    start = 1'b0;
    check("busy_start_addr", mem_addr, 32'd3);
    check("busy_start_busy", 32'(busy), 32'd1);
    send(8'hA4);
    byte_in    = 8'hA5;
    byte_valid = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_zero("midrst");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    check("midrst_count", 32'(wr_n - base), 32'd5);
    for (int i = 0; i < 5; i++)
      check($sformatf("midrst_addr%0d", i), log_a[base + i], 32'(i));
    check("midrst_cs", 32'(cs_rom), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);

`ifdef LOADER_CHECKSUM_EN
    // Good checksum: 08^00^01^20 = 29
    do_start(6'd1);
    for (int i = 0; i < 4; i++) send(prog[i]);
    check("ck_in_check_busy", 32'(busy), 32'd1);
    check("ck_in_check_done", 32'(done), 32'd0);
    send(8'h29);
    check("ck_no_write", 32'(mem_we), 32'd0);
    check("ck_done", 32'(done), 32'd1);
    check("ck_cs", 32'(cs_rom), 32'd1);
    check("ck_err", 32'(err), 32'd0);
    // Bad checksum
    do_start(6'd1);
    for (int i = 0; i < 4; i++) send(prog[i]);
    send(8'h00);
    check("ckbad_err", 32'(err), 32'd1);
    check("ckbad_done", 32'(done), 32'd0);
    check("ckbad_cs", 32'(cs_rom), 32'd0);
    check("ckbad_busy", 32'(busy), 32'd0);
    check("ckbad_ready", 32'(byte_ready), 32'd0);
    idle(2);
    check("ckbad_sticky", 32'(err), 32'd1);
    do_start(6'd1);
    check("ckbad_clear", 32'(err), 32'd0);
    check("ckbad_restart", 32'(busy), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
